// File: rtl/ysyx_24080006_hpm_bank_pkg.sv
// Shared definitions for the machine-mode performance-counter bank:
// counter-space CSR addresses, event_i bit naming and the implemented-index mask.
package ysyx_24080006_pkg;

    localparam logic [11:0] MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] MHPMEVENT3    = 12'h323;
    localparam logic [11:0] MCYCLE        = 12'hB00;
    localparam logic [11:0] MINSTRET      = 12'hB02;
    localparam logic [11:0] MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] MCYCLEH       = 12'hB80;
    localparam logic [11:0] MINSTRETH     = 12'hB82;
    localparam logic [11:0] MHPMCOUNTER3H = 12'hB83;

    // Bit positions within event_i; mhpmevent value is position + 1.
    typedef enum logic [7:0] {
        EV_ICACHE_HIT   = 8'd0,
        EV_ICACHE_MISS  = 8'd1,
        EV_ICACHE_SKIP  = 8'd2,
        EV_LOAD_NUM     = 8'd3,
        EV_LOAD_CYCLE   = 8'd4,
        EV_STORE_NUM    = 8'd5,
        EV_STORE_CYCLE  = 8'd6,
        EV_COMPRESSED   = 8'd7,
        EV_FETCH_CYCLE  = 8'd8
    } hpm_event_e;

    // Counter indexes backed by real state: 0 (cycle), 2 (instret), 3..2+num_hpm.
    function automatic logic [31:0] cnt_impl_mask(input int unsigned num_hpm);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i == 0 || (i >= 2 && i <= 2 + num_hpm)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/ysyx_24080006_hpm_bank_if.sv
// Decoded counter-space CSR access forwarded from the CSR unit, with the bank's hit/read-data reply.
interface ysyx_24080006_hpm_bank_if;

    logic [11:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic        csr_hit;
    logic [31:0] csr_rdata;

    modport master (
        output csr_addr, csr_we, csr_wdata,
        input  csr_hit, csr_rdata
    );

    modport slave (
        input  csr_addr, csr_we, csr_wdata,
        output csr_hit, csr_rdata
    );

endinterface

// File: rtl/ysyx_24080006_hpm_counter.sv
// One software-writable wrapping counter with a sticky overflow flag.
module ysyx_24080006_hpm_counter #(
    parameter int unsigned CNT_WIDTH = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 incr_en,
    input  logic                 low_we,
    input  logic                 high_we,
    input  logic [31:0]          wdata,
    output logic [CNT_WIDTH-1:0] value,
    output logic                 ovf
);

    logic [CNT_WIDTH-1:0] wr_value;

    always_comb begin
        wr_value = value;
        if (low_we)  wr_value[31:0]           = wdata;
        if (high_we) wr_value[CNT_WIDTH-1:32] = wdata[CNT_WIDTH-33:0];
    end

    // A software write suppresses both the increment and any wrap in that cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= '0;
            ovf   <= 1'b0;
        end else if (low_we || high_we) begin
            value <= wr_value;
            ovf   <= 1'b0;
        end else if (incr_en) begin
            value <= value + 1'b1;
            if (&value) ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_24080006_hpm_bank.sv
// Machine-mode performance-counter bank: mcycle, minstret, NUM_HPM event counters,
// mhpmevent selectors and mcountinhibit, accessed through the forwarded CSR port.
module ysyx_24080006_hpm_bank
    import ysyx_24080006_pkg::*;
#(
    parameter int unsigned NUM_HPM    = 8,
    parameter int unsigned NUM_EVENTS = 16,
    parameter int unsigned CNT_WIDTH  = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    instret,
    input  logic [NUM_EVENTS-1:0]   event_i,
    ysyx_24080006_hpm_bank_if.slave csr,
    output logic [2+NUM_HPM:0]      ovf_o
);

    localparam int unsigned NUM_CNT   = 3 + NUM_HPM;
    localparam logic [31:0] IMPL_MASK = cnt_impl_mask(NUM_HPM);

    logic [31:0]          inhibit_q;
    logic [7:0]           event_sel_q [32];
    logic [4:0]           idx;
    logic                 idx_impl;
    logic                 sel_inhibit, sel_event, sel_lo, sel_hi;
    logic [NUM_CNT-1:0]   incr_en, low_we, high_we, cnt_ovf;
    logic [CNT_WIDTH-1:0] cnt_val [NUM_CNT];
    logic [63:0]          rd_cnt;

    assign idx      = csr.csr_addr[4:0];
    assign idx_impl = IMPL_MASK[idx];

    // Whole 32-entry windows are claimed so unimplemented indexes read as WARL zero.
    assign sel_inhibit = (csr.csr_addr == MCOUNTINHIBIT);
    assign sel_event   = (csr.csr_addr[11:5] == MCOUNTINHIBIT[11:5]) && (idx >= 5'd3);
    assign sel_lo      = (csr.csr_addr[11:5] == MCYCLE[11:5])  && (idx != 5'd1);
    assign sel_hi      = (csr.csr_addr[11:5] == MCYCLEH[11:5]) && (idx != 5'd1);
    assign csr.csr_hit = sel_inhibit || sel_event || sel_lo || sel_hi;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inhibit_q <= '0;
            for (int unsigned i = 0; i < 32; i++) event_sel_q[i] <= '0;
        end else if (csr.csr_we) begin
            if (sel_inhibit)             inhibit_q        <= csr.csr_wdata & IMPL_MASK;
            if (sel_event && idx_impl)   event_sel_q[idx] <= csr.csr_wdata[7:0];
        end
    end

    always_comb begin
        logic fire;
        incr_en    = '0;
        incr_en[0] = ~inhibit_q[0];
        incr_en[2] = instret & ~inhibit_q[2];
        for (int unsigned i = 3; i < NUM_CNT; i++) begin
            fire = 1'b0;
            for (int unsigned k = 0; k < NUM_EVENTS; k++) begin
                if (event_sel_q[i] == 8'(k + 1) && event_i[k]) fire = 1'b1;
            end
            incr_en[i] = fire & ~inhibit_q[i];
        end
    end

    always_comb begin
        low_we  = '0;
        high_we = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            if (idx == 5'(i)) begin
                low_we[i]  = csr.csr_we && sel_lo;
                high_we[i] = csr.csr_we && sel_hi;
            end
        end
    end

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        if (g == 1) begin : g_tie
            assign cnt_val[g] = '0;
            assign cnt_ovf[g] = 1'b0;
        end else begin : g_inst
            ysyx_24080006_hpm_counter #(
                .CNT_WIDTH(CNT_WIDTH)
            ) u_cnt (
                .clock   (clock),
                .reset   (reset),
                .incr_en (incr_en[g]),
                .low_we  (low_we[g]),
                .high_we (high_we[g]),
                .wdata   (csr.csr_wdata),
                .value   (cnt_val[g]),
                .ovf     (cnt_ovf[g])
            );
        end
    end

    assign ovf_o = cnt_ovf;

    always_comb begin
        rd_cnt = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            if (idx == 5'(i)) rd_cnt = 64'(cnt_val[i]);
        end
    end

    always_comb begin
        csr.csr_rdata = '0;
        if (sel_inhibit)                csr.csr_rdata = inhibit_q;
        else if (sel_event && idx_impl) csr.csr_rdata = {24'h0, event_sel_q[idx]};
        else if (sel_lo && idx_impl)    csr.csr_rdata = rd_cnt[31:0];
        else if (sel_hi && idx_impl)    csr.csr_rdata = rd_cnt[63:32];
    end

endmodule

// File: tb/tb_ysyx_24080006_hpm_bank.sv
// Self-checking bench for the performance-counter bank (40-bit counters, 8 event counters).
module tb_ysyx_24080006_hpm_bank;
    import ysyx_24080006_pkg::*;

    localparam int unsigned NH = 8;
    localparam int unsigned NE = 16;
    localparam int unsigned CW = 40;

    logic          clock = 1'b0;
    logic          reset;
    logic          instret;
    logic [NE-1:0] event_i;
    logic [2+NH:0] ovf_o;

    ysyx_24080006_hpm_bank_if csr ();

    ysyx_24080006_hpm_bank #(
        .NUM_HPM    (NH),
        .NUM_EVENTS (NE),
        .CNT_WIDTH  (CW)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .instret (instret),
        .event_i (event_i),
        .csr     (csr),
        .ovf_o   (ovf_o)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic        hit;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        string       name;
        logic [11:0] addr;
        logic        hit;
        logic [31:0] data;
    } vec_t;

    exp_t sb[$];
    vec_t rst_tbl[$];

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_out();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: no expectation queued, got hit=%0b rdata=0x%08h",
                     csr.csr_hit, csr.csr_rdata);
        end else begin
            e = sb.pop_front();
            if (csr.csr_hit !== e.hit || csr.csr_rdata !== e.data) begin
                errors++;
                $display("FAIL %s: got hit=%0b rdata=0x%08h, expected hit=%0b rdata=0x%08h",
                         e.name, csr.csr_hit, csr.csr_rdata, e.hit, e.data);
            end
        end
    endtask

    task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] data,
                      input logic hit = 1'b1);
        exp_t e;
        e.name = name;
        e.hit  = hit;
        e.data = data;
        csr.csr_addr = addr;
        sb.push_back(e);
        #1;
        check_out();
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        csr.csr_addr  = addr;
        csr.csr_wdata = data;
        csr.csr_we    = 1'b1;
        tick(1);
        csr.csr_we    = 1'b0;
    endtask

    task automatic chk_ovf(input string name, input logic [2+NH:0] exp);
        checks++;
        if (ovf_o !== exp) begin
            errors++;
            $display("FAIL %s: got ovf_o=0x%03h, expected 0x%03h", name, ovf_o, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        rst_tbl.push_back('{"mcycle_idle",     MCYCLE,            1'b1, 32'd10});
        rst_tbl.push_back('{"mcycleh_idle",    MCYCLEH,           1'b1, 32'd0});
        rst_tbl.push_back('{"minstret_idle",   MINSTRET,          1'b1, 32'd0});
        rst_tbl.push_back('{"minstreth_idle",  MINSTRETH,         1'b1, 32'd0});
        rst_tbl.push_back('{"hpm3_idle",       MHPMCOUNTER3,      1'b1, 32'd0});
        rst_tbl.push_back('{"hpm10_idle",      12'hB0A,           1'b1, 32'd0});
        rst_tbl.push_back('{"hpm11_unimpl",    12'hB0B,           1'b1, 32'd0});
        rst_tbl.push_back('{"hpm31h_unimpl",   12'hB9F,           1'b1, 32'd0});
        rst_tbl.push_back('{"inhibit_rst",     MCOUNTINHIBIT,     1'b1, 32'd0});
        rst_tbl.push_back('{"event3_rst",      MHPMEVENT3,        1'b1, 32'd0});
        rst_tbl.push_back('{"event31_unimpl",  12'h33F,           1'b1, 32'd0});
        rst_tbl.push_back('{"addr321_miss",    12'h321,           1'b0, 32'd0});
        rst_tbl.push_back('{"addrB01_miss",    12'hB01,           1'b0, 32'd0});
        rst_tbl.push_back('{"addr300_miss",    12'h300,           1'b0, 32'd0});

        reset         = 1'b1;
        instret       = 1'b0;
        event_i       = '0;
        csr.csr_addr  = '0;
        csr.csr_we    = 1'b0;
        csr.csr_wdata = '0;
        tick(2);
        chk_ovf("ovf_in_reset", '0);
        rd("mcycle_in_reset", MCYCLE, 32'd0);

        reset = 1'b0;
        tick(10);
        for (int i = 0; i < rst_tbl.size(); i++)
            rd(rst_tbl[i].name, rst_tbl[i].addr, rst_tbl[i].data, rst_tbl[i].hit);
        chk_ovf("ovf_idle", '0);

        // Event selection, including an out-of-range selector and the top legal one.
        wr(MHPMEVENT3, 32'd2);
        wr(12'h325, 32'h0000_01FF);
        wr(12'h326, 32'd16);
        rd("event3_rb", MHPMEVENT3, 32'd2);
        rd("event5_rb_trunc", 12'h325, 32'h0000_00FF);
        event_i = 16'h8002;
        tick(5);
        event_i = 16'h0001;
        tick(3);
        event_i = 16'hFFFF;
        tick(2);
        event_i = '0;
        rd("hpm3_events", MHPMCOUNTER3, 32'd7);
        rd("hpm4_sel0", 12'hB04, 32'd0);
        rd("hpm5_sel_oob", 12'hB05, 32'd0);
        rd("hpm6_sel_max", 12'hB06, 32'd7);

        // Low-to-high carry.
        wr(MCYCLE, 32'hFFFF_FFFF);
        wr(MCYCLEH, 32'd0);
        tick(2);
        rd("mcycle_carry_lo", MCYCLE, 32'd1);
        rd("mcycle_carry_hi", MCYCLEH, 32'd1);

        // Wrap at 40 bits with sticky overflow.
        wr(MHPMCOUNTER3, 32'hFFFF_FFFF);
        wr(MHPMCOUNTER3H, 32'hFFFF_FFFF);
        rd("hpm3h_width", MHPMCOUNTER3H, 32'h0000_00FF);
        rd("hpm3_allones", MHPMCOUNTER3, 32'hFFFF_FFFF);
        chk_ovf("ovf_before_wrap", '0);
        event_i = 16'h0002;
        tick(1);
        event_i = '0;
        rd("hpm3_wrap_lo", MHPMCOUNTER3, 32'd0);
        rd("hpm3_wrap_hi", MHPMCOUNTER3H, 32'd0);
        chk_ovf("ovf_wrap", 11'h008);
        tick(3);
        chk_ovf("ovf_sticky", 11'h008);
        wr(MHPMCOUNTER3, 32'd0);
        chk_ovf("ovf_cleared", '0);

        // Inhibit masking and freeze.
        wr(MCOUNTINHIBIT, 32'hFFFF_FFFF);
        rd("inhibit_mask", MCOUNTINHIBIT, 32'h0000_07FD);
        wr(MCOUNTINHIBIT, 32'h5);
        rd("inhibit_rb", MCOUNTINHIBIT, 32'h5);
        wr(MCYCLE, 32'h100);
        wr(MINSTRET, 32'h20);
        instret = 1'b1;
        tick(4);
        rd("mcycle_frozen", MCYCLE, 32'h100);
        rd("minstret_frozen", MINSTRET, 32'h20);
        wr(MCOUNTINHIBIT, 32'h0);
        rd("mcycle_release_cycle", MCYCLE, 32'h100);
        tick(3);
        instret = 1'b0;
        rd("mcycle_resumed", MCYCLE, 32'h103);
        rd("minstret_resumed", MINSTRET, 32'h23);
        wr(12'h321, 32'hFFFF_FFFF);
        rd("miss_write_ignored", MCOUNTINHIBIT, 32'h0);

        // Write beats a same-cycle increment.
        wr(12'h324, 32'd1);
        csr.csr_addr  = 12'hB04;
        csr.csr_wdata = 32'h100;
        csr.csr_we    = 1'b1;
        event_i       = 16'h0001;
        tick(1);
        csr.csr_we    = 1'b0;
        event_i       = '0;
        rd("hpm4_write_wins", 12'hB04, 32'h100);
        event_i = 16'h0001;
        tick(1);
        event_i = '0;
        rd("hpm4_after_event", 12'hB04, 32'h101);

        // Write beats a same-cycle wrap.
        wr(MHPMCOUNTER3H, 32'hFF);
        wr(MHPMCOUNTER3, 32'hFFFF_FFFF);
        csr.csr_addr  = MHPMCOUNTER3H;
        csr.csr_wdata = 32'h12;
        csr.csr_we    = 1'b1;
        event_i       = 16'h0002;
        tick(1);
        csr.csr_we    = 1'b0;
        event_i       = '0;
        rd("hpm3h_write_vs_wrap", MHPMCOUNTER3H, 32'h12);
        rd("hpm3_write_vs_wrap", MHPMCOUNTER3, 32'hFFFF_FFFF);
        chk_ovf("ovf_write_vs_wrap", '0);

        // Reset in the middle of counting.
        instret = 1'b1;
        event_i = '1;
        tick(3);
        reset = 1'b1;
        #1;
        chk_ovf("ovf_mid_reset", '0);
        rd("mcycle_mid_reset", MCYCLE, 32'd0);
        rd("minstret_mid_reset", MINSTRET, 32'd0);
        rd("hpm4_mid_reset", 12'hB04, 32'd0);
        rd("hpm3h_mid_reset", MHPMCOUNTER3H, 32'd0);
        rd("event4_mid_reset", 12'h324, 32'd0);
        reset = 1'b0;
        tick(2);
        instret = 1'b0;
        event_i = '0;
        rd("mcycle_restart", MCYCLE, 32'd2);
        rd("minstret_restart", MINSTRET, 32'd2);
        rd("hpm4_restart", 12'hB04, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
